// File: rtl/pl_mem_wb.sv
// Memory-access / write-back stage: issues data-memory requests over a req/ready
// handshake, stalls upstream while waiting, drives the RF write port and holds condition flags.
module pl_mem_wb #(
   parameter int NUM_DOMAINS = 1,
   parameter int ADDR_WID    = 16,
   parameter int MEM_TIMEOUT = 255,
   localparam int DW         = NUM_DOMAINS * 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [0:6]          ex_ctrl,
   input  logic [2:0]          ex_dest_addr,
   input  logic [DW-1:0]       ex_result,
   input  logic [ADDR_WID-1:0] ex_wr_addr,
   input  logic [ADDR_WID-1:0] ex_rd_addr,
   input  logic [0:4]          ex_branch_conds,
   output logic                stall,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_WID-1:0] mem_addr,
   output logic [DW-1:0]       mem_wdata,
   input  logic [DW-1:0]       mem_rdata,
   input  logic                mem_ready,
   output logic                rf_wr_en,
   output logic [2:0]          rf_wr_addr,
   output logic [DW-1:0]       rf_wr_data,
   output logic                flag_gt,
   output logic                flag_lt,
   output logic                flag_eq,
   output logic                flag_carry,
   output logic                mem_err
);

   // Counter only needs to reach MEM_TIMEOUT-1; the terminal WAIT cycle aborts.
   localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_WAIT = 1'b1;

   logic [0:0]          r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_mem_req;
   logic                r_mem_we;
   logic [ADDR_WID-1:0] r_mem_addr;
   logic [DW-1:0]       r_mem_wdata;
   logic                r_load_wr;
   logic [2:0]          r_dest;
   logic                r_rf_wr_en;
   logic [2:0]          r_rf_wr_addr;
   logic [DW-1:0]       r_rf_wr_data;
   logic                r_flag_gt;
   logic                r_flag_lt;
   logic                r_flag_eq;
   logic                r_flag_carry;
   logic                r_mem_err;

   logic w_valid;
   logic w_store;
   logic w_load;
   logic w_unused;

   assign w_valid  = ~ex_ctrl[3];
   assign w_store  = w_valid & ex_ctrl[0];
   assign w_load   = w_valid & ex_ctrl[4] & ~ex_ctrl[0];
   assign w_unused = ^ex_ctrl[5:6];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_mem_req    <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_load_wr    <= 1'b0;
         r_dest       <= '0;
         r_rf_wr_en   <= 1'b0;
         r_rf_wr_addr <= '0;
         r_rf_wr_data <= '0;
         r_flag_gt    <= 1'b0;
         r_flag_lt    <= 1'b0;
         r_flag_eq    <= 1'b0;
         r_flag_carry <= 1'b0;
         r_mem_err    <= 1'b0;
      end else begin
         r_rf_wr_en <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_valid) begin
                  if (ex_branch_conds[4]) begin
                     r_flag_gt <= ex_branch_conds[0];
                     r_flag_lt <= ex_branch_conds[1];
                     r_flag_eq <= ex_branch_conds[2];
                  end
                  if (ex_ctrl[2])
                     r_flag_carry <= ex_branch_conds[3];
                  // Store takes priority when both memory bits are set.
                  if (w_store || w_load) begin
                     r_state    <= S_WAIT;
                     r_cnt      <= '0;
                     r_mem_req  <= 1'b1;
                     r_mem_we   <= w_store;
                     r_mem_addr <= w_store ? ex_wr_addr : ex_rd_addr;
                     if (w_store)
                        r_mem_wdata <= ex_result;
                     r_load_wr  <= w_load & ex_ctrl[1];
                     r_dest     <= ex_dest_addr;
                  end else if (ex_ctrl[1]) begin
                     r_rf_wr_en   <= 1'b1;
                     r_rf_wr_addr <= ex_dest_addr;
                     r_rf_wr_data <= ex_result;
                  end
               end
            end
            default: begin
               if (mem_ready) begin
                  r_state   <= S_IDLE;
                  r_mem_req <= 1'b0;
                  r_mem_we  <= 1'b0;
                  if (r_load_wr) begin
                     r_rf_wr_en   <= 1'b1;
                     r_rf_wr_addr <= r_dest;
                     r_rf_wr_data <= mem_rdata;
                  end
               end else if (r_cnt == CNT_LAST) begin
                  r_state   <= S_IDLE;
                  r_mem_req <= 1'b0;
                  r_mem_we  <= 1'b0;
                  r_mem_err <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
         endcase
      end
   end

   assign stall      = (r_state == S_WAIT);
   assign mem_req    = r_mem_req;
   assign mem_we     = r_mem_we;
   assign mem_addr   = r_mem_addr;
   assign mem_wdata  = r_mem_wdata;
   assign rf_wr_en   = r_rf_wr_en;
   assign rf_wr_addr = r_rf_wr_addr;
   assign rf_wr_data = r_rf_wr_data;
   assign flag_gt    = r_flag_gt;
   assign flag_lt    = r_flag_lt;
   assign flag_eq    = r_flag_eq;
   assign flag_carry = r_flag_carry;
   assign mem_err    = r_mem_err;

endmodule

// File: tb/tb_pl_mem_wb.sv
// Bench for pl_mem_wb: transaction-level model feeds expectation queues that a
// negedge monitor drains; a memory responder answers requests with planned latencies.
module tb_pl_mem_wb;
   localparam int DW  = 8;
   localparam int AW  = 16;
   localparam int TMO = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [0:6]    ex_ctrl;
   logic [2:0]    ex_dest_addr;
   logic [DW-1:0] ex_result;
   logic [AW-1:0] ex_wr_addr, ex_rd_addr;
   logic [0:4]    ex_branch_conds;
   logic          stall, mem_req, mem_we, mem_ready, rf_wr_en;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata, rf_wr_data;
   logic [2:0]    rf_wr_addr;
   logic          flag_gt, flag_lt, flag_eq, flag_carry, mem_err;

   pl_mem_wb #(.NUM_DOMAINS(1), .ADDR_WID(AW), .MEM_TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .ex_ctrl(ex_ctrl), .ex_dest_addr(ex_dest_addr),
      .ex_result(ex_result), .ex_wr_addr(ex_wr_addr), .ex_rd_addr(ex_rd_addr),
      .ex_branch_conds(ex_branch_conds), .stall(stall), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .rf_wr_en(rf_wr_en),
      .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data), .flag_gt(flag_gt),
      .flag_lt(flag_lt), .flag_eq(flag_eq), .flag_carry(flag_carry), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   typedef struct { logic [AW-1:0] addr; logic we; logic [DW-1:0] wdata; int len; int start; bit tmo; } txn_t;
   typedef struct { logic [2:0] addr; logic [DW-1:0] data; int cyc; } rfw_t;
   typedef struct { int d; logic [DW-1:0] rdata; } rsp_t;

   txn_t txn_q[$];
   rfw_t rf_q[$];
   rsp_t rsp_q[$];

   int   tests = 0, fails = 0, cyc = 0;
   bit   mon_on = 1'b0;
   logic [3:0] exp_flags = 4'b0;   // {gt, lt, eq, carry}
   bit   exp_err = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops expectations whenever the DUT presents a request or a write-back.
   txn_t cur;
   rfw_t re;
   logic [DW-1:0] cap_wdata;
   int   mcnt = 0;
   bit   prev_req = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (mon_on) begin
         if (mem_req && !prev_req) begin
            if (txn_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL mem_unexpected: request addr 0x%0h we %0b, none expected", mem_addr, mem_we);
               cur = '{addr: mem_addr, we: mem_we, wdata: mem_wdata, len: -1, start: cyc, tmo: 1'b0};
            end else begin
               cur = txn_q.pop_front();
               chk("mem_addr", mem_addr, cur.addr);
               chk("mem_we", mem_we, cur.we);
               if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
               chk("mem_start_cycle", cyc, cur.start);
            end
            cap_wdata = mem_wdata;
            mcnt = 1;
         end else if (mem_req && prev_req) begin
            mcnt++;
            chk("mem_hold", {mem_addr, mem_we, mem_wdata}, {cur.addr, cur.we, cap_wdata});
         end else if (!mem_req && prev_req) begin
            chk("mem_req_len", mcnt, cur.len);
            if (cur.tmo) exp_err = 1'b1;
         end
         if (rf_wr_en) begin
            if (rf_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL rf_unexpected: write addr %0d data 0x%0h, none expected", rf_wr_addr, rf_wr_data);
            end else begin
               re = rf_q.pop_front();
               chk("rf_wr_addr", rf_wr_addr, re.addr);
               chk("rf_wr_data", rf_wr_data, re.data);
               chk("rf_wr_cycle", cyc, re.cyc);
            end
         end
         chk("flags", {flag_gt, flag_lt, flag_eq, flag_carry}, exp_flags);
         chk("mem_err", mem_err, exp_err);
         chk("stall_vs_req", stall, mem_req);
      end
      prev_req = mem_req;
   end

   // Memory responder: ready on the d-th request cycle (d=0: never), noise on ready when idle.
   rsp_t rsp;
   int   rcnt = 0;
   initial begin
      mem_ready = 1'b0;
      mem_rdata = '0;
      rsp = '{d: 0, rdata: '0};
      forever begin
         @(posedge clk); #1;
         if (mem_req) begin
            if (rcnt == 0) begin
               if (rsp_q.size() > 0) rsp = rsp_q.pop_front();
               else rsp = '{d: 0, rdata: '0};
            end
            rcnt++;
            mem_ready = (rcnt == rsp.d);
            mem_rdata = (rcnt == rsp.d) ? rsp.rdata : DW'($urandom);
         end else begin
            rcnt = 0;
            mem_ready = ($urandom_range(0, 3) == 0);
            mem_rdata = DW'($urandom);
         end
      end
   end

   function automatic logic [0:6] mk_ctrl(input bit st, input bit rw, input bit sc, input bit inv, input bit ld);
      logic [0:6] c;
      c[0] = st; c[1] = rw; c[2] = sc; c[3] = inv; c[4] = ld;
      c[5] = 1'($urandom_range(0, 1));
      c[6] = 1'($urandom_range(0, 1));
      return c;
   endfunction

   task automatic drive_idle();
      ex_ctrl = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      ex_dest_addr = '0; ex_result = '0; ex_wr_addr = '0; ex_rd_addr = '0;
      ex_branch_conds = '0;
   endtask

   // Entered and left at posedge+1; waits out stall while waving a bundle the DUT must ignore.
   task automatic send(input logic [0:6] ctrl, input logic [2:0] dest, input logic [DW-1:0] res,
                       input logic [AW-1:0] wa, input logic [AW-1:0] ra, input logic [0:4] cond,
                       input int d, input logic [DW-1:0] rdata, input int abort_len);
      int n = 0;
      int c;
      bit valid, st, ld, succ;
      while (stall) begin
         if (n >= 20) begin
            fails++;
            $display("FAIL stall_bound: stall still %0b after %0d cycles, expected 0", stall, n);
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
         end
         ex_ctrl = mk_ctrl(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
         ex_dest_addr = 3'($urandom); ex_result = DW'($urandom);
         ex_branch_conds = {3'($urandom), 1'($urandom), 1'b1};
         @(posedge clk); #1;
         n++;
      end
      ex_ctrl = ctrl; ex_dest_addr = dest; ex_result = res;
      ex_wr_addr = wa; ex_rd_addr = ra; ex_branch_conds = cond;
      c = cyc;
      valid = !ctrl[3];
      st = valid && ctrl[0];
      ld = valid && ctrl[4] && !ctrl[0];
      if (st || ld) begin
         succ = (d > 0) && (d <= TMO);
         txn_q.push_back('{addr: st ? wa : ra, we: st, wdata: res,
                           len: (abort_len > 0) ? abort_len : (succ ? d : TMO),
                           start: c + 2, tmo: !succ && (abort_len == 0)});
         rsp_q.push_back('{d: d, rdata: rdata});
         if (ld && ctrl[1] && succ && abort_len == 0)
            rf_q.push_back('{addr: dest, data: rdata, cyc: c + d + 2});
      end else if (valid && ctrl[1]) begin
         rf_q.push_back('{addr: dest, data: res, cyc: c + 2});
      end
      @(posedge clk); #1;
      if (valid) begin
         if (cond[4]) exp_flags[3:1] = {cond[0], cond[1], cond[2]};
         if (ctrl[2]) exp_flags[0] = cond[3];
      end
      drive_idle();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      exp_flags = 4'b0;
      exp_err = 1'b0;
   endtask

   task automatic idle_send();
      send(mk_ctrl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0), 3'd0, 8'h00, 16'h0, 16'h0, 5'b0, 0, 8'h00, 0);
   endtask

   initial begin
      int kind, d;
      logic [0:6] ctrl;
      reset = 1'b1;
      drive_idle();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      mon_on = 1'b1;
      @(negedge clk); #1;
      chk("reset_state", {stall, mem_req, mem_we, rf_wr_en, flag_gt, flag_lt, flag_eq, flag_carry,
                          mem_err, mem_addr, mem_wdata, rf_wr_addr, rf_wr_data}, 64'd0);
      @(posedge clk); #1;

      // ALU write-back, store with 3-cycle memory, zero-wait load
      send(mk_ctrl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 3'd3, 8'h5A, 16'h0, 16'h0, 5'b0, 0, 8'h00, 0);
      send(mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 3'd1, 8'hC3, 16'h0102, 16'h0999, 5'b0, 3, 8'hEE, 0);
      send(mk_ctrl(1'b0, 1'b1, 1'b0, 1'b0, 1'b1), 3'd5, 8'h00, 16'h0, 16'h0040, 5'b0, 1, 8'h77, 0);

      // Flags: compare, invalid bundle that must not disturb them, then carry save
      send(mk_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 3'd0, 8'h00, 16'h0, 16'h0, 5'b01001, 0, 8'h00, 0);
      send(mk_ctrl(1'b0, 1'b1, 1'b1, 1'b1, 1'b1), 3'd6, 8'h11, 16'h0, 16'h0, 5'b10111, 1, 8'h00, 0);
      send(mk_ctrl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0), 3'd0, 8'h00, 16'h0, 16'h0, 5'b00010, 0, 8'h00, 0);
      chk("flags_directed", {flag_gt, flag_lt, flag_eq, flag_carry}, 4'b0101);

      // Load that never completes: timeout, sticky error, cleared by reset
      send(mk_ctrl(1'b0, 1'b1, 1'b0, 1'b0, 1'b1), 3'd2, 8'h00, 16'h0, 16'h0123, 5'b0, 0, 8'h00, 0);
      idle_send();
      repeat (3) @(posedge clk);
      #1;
      chk("mem_err_sticky", mem_err, 1'b1);
      do_reset();
      chk("mem_err_cleared", mem_err, 1'b0);

      // Reset on the second WAIT cycle of a load
      send(mk_ctrl(1'b0, 1'b1, 1'b0, 1'b0, 1'b1), 3'd4, 8'h00, 16'h0, 16'h0200, 5'b0, 0, 8'h00, 2);
      @(posedge clk); #1;
      do_reset();
      chk("reset_abort_req_stall", {mem_req, stall}, 2'b00);

      for (int i = 0; i < 250; i++) begin
         kind = $urandom_range(0, 9);
         ctrl = mk_ctrl(1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'($urandom));
         if (kind < 2) ctrl[3] = 1'b1;
         else if (kind < 5) begin ctrl[0] = 1'b0; ctrl[4] = 1'b0; end
         else if (kind < 7) begin ctrl[0] = 1'b1; ctrl[4] = 1'b0; end
         else if (kind < 9) begin ctrl[0] = 1'b0; ctrl[4] = 1'b1; end
         else begin ctrl[0] = 1'b1; ctrl[4] = 1'b1; end
         d = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
         send(ctrl, 3'($urandom), DW'($urandom), AW'($urandom), AW'($urandom), 5'($urandom),
              d, DW'($urandom), 0);
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         if ($urandom_range(0, 39) == 0) begin
            idle_send();
            do_reset();
         end
      end

      idle_send();
      repeat (4) @(posedge clk);
      #1;
      chk("txn_queue_drained", txn_q.size(), 0);
      chk("rf_queue_drained", rf_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/pl_mem_wb.md
# pl_mem_wb

Memory-access and write-back stage of the RNS pipeline; consumes the registered EX-stage bundle (control vector, result, addresses, branch conditions). Issues data-memory reads/writes over a req/ready handshake and stalls upstream while an access is outstanding. Drives the register-file write port and holds the architectural condition flags (gt/lt/eq/carry) consumed by the branch unit.

## Interface
- NUM_DOMAINS, 1, number of 8-bit RNS domains; data width DW = NUM_DOMAINS*8
- ADDR_WID, 16, data-memory address width
- MEM_TIMEOUT, 255, max cycles in WAIT before abort (≥1)
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ex_ctrl  in  [0:6]  {store, reg_wr_en, save_cout, invalidate, load, inv_fetch, inv_decode}
- ex_dest_addr  in  3  destination register
- ex_result  in  DW  ALU result, or store data when store=1
- ex_wr_addr, ex_rd_addr  in  ADDR_WID each  store/load address
- ex_branch_conds  in  [0:4]  {gt, lt, eq, carry, compare_true}
- stall  out  1  upstream must hold its bundle while high
- mem_req  out  1  access request
- mem_we  out  1  1=write, 0=read
- mem_addr  out  ADDR_WID
- mem_wdata  out  DW
- mem_rdata  in  DW  valid when mem_ready=1 on a read
- mem_ready  in  1  access complete this cycle
- rf_wr_en  out  1
- rf_wr_addr  out  3
- rf_wr_data  out  DW
- flag_gt, flag_lt, flag_eq, flag_carry  out  1 each  condition flags
- mem_err  out  1  sticky; set on timeout, cleared only by reset

## Operation
- Bundle valid = !ex_ctrl[3]; inv_fetch/inv_decode bits ignored here. Invalid bundle: no memory access, no rf write, no flag update.
- States: IDLE, WAIT.
- IDLE, valid bundle with store=1: latch address/data/dest, mem_req=1, mem_we=1, mem_addr=ex_wr_addr, mem_wdata=ex_result; go WAIT.
- IDLE, valid with load=1 (store=0): mem_req=1, mem_we=0, mem_addr=ex_rd_addr; go WAIT. store=load=1: store wins, load dropped.
- IDLE, valid non-memory with reg_wr_en=1: rf_wr_en=1, rf_wr_addr=ex_dest_addr, rf_wr_data=ex_result next cycle.
- WAIT: mem_req, mem_we, mem_addr, mem_wdata held stable; stall=1; timeout counter increments. On mem_ready=1: drop mem_req next edge, return IDLE; load with reg_wr_en=1 → rf_wr_en=1, rf_wr_data=mem_rdata sampled that edge. Store never writes rf.
- Timeout: counter reaches MEM_TIMEOUT without ready → mem_err=1, drop request, IDLE, no rf write.
- Flags (valid bundles only, updated at issue): compare_true=1 → gt/lt/eq ← ex_branch_conds[0:2]; save_cout=1 → flag_carry ← ex_branch_conds[3]. Otherwise flags hold.
- Bundles presented while stall=1 are not sampled.

## Timing
- Reset (sync): state IDLE; stall, mem_req, mem_we, rf_wr_en, all flags, mem_err, counter = 0; mem_addr, mem_wdata, rf_wr_addr, rf_wr_data = 0.
- Reset mid-WAIT: mem_req deasserts on that edge; pending load writes nothing.
- Non-memory write-back: rf_wr_en high exactly 1 cycle, the cycle after bundle sampled.
- Memory: mem_req rises the cycle after issue; stall = (state==WAIT), combinational from state.
- Zero-wait memory (ready on first request cycle): 1 stall cycle; load rf_wr_en the following cycle.
- Load latency: issue edge → rf_wr_en = 1 + number of cycles to ready + 1.
- rf_wr_en is a 1-cycle pulse; never asserted while state==WAIT except the post-ready pulse.
- mem_ready while mem_req=0 ignored.

## Test plan
- Reset, then valid ALU bundle dest=3, result=0x5A, reg_wr_en=1 → next cycle rf_wr_en=1, addr=3, data=0x5A; one cycle only.
- Store addr=0x0102, data=0xC3, ready after 3 cycles → mem_req/mem_we=1 with stable addr/data for 3 cycles, stall=1 same span, no rf write.
- Load addr=0x0040, dest=5, ready on first cycle, rdata=0x77 → 1 stall cycle, then rf_wr_en=1, addr=5, data=0x77.
- Compare bundle {gt=0,lt=1,eq=0,compare_true=1} then invalid bundle with {gt=1,eq=1} → flags stay lt=1 only; save_cout=1, carry bit=1 → flag_carry=1.
- Load, mem_ready never asserted, MEM_TIMEOUT=4 → mem_req drops after 4 WAIT cycles, mem_err=1 and sticky, no rf write; reset clears.
- Reset asserted on 2nd WAIT cycle of a load → mem_req=0, stall=0 next cycle, no rf_wr_en pulse.
